soc_system_read_data: RTL and testbench

// Avalon-MM input PIO slave that software polls to read data back from the logging logic.
// It is the receive-side counterpart of the HPS-driven output PIOs (e.g. the read clock strobe).
// - Synchronises an external WIDTH-bit bus into clk.
// - Captures edges per bit and raises a maskable interrupt.

---
 rtl/soc_system_read_data.sv | 124 ++++++++++++
 tb/tb_soc_system_read_data.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_read_data.sv
`default_nettype none
// ============================================================================
//  Module   : soc_system_read_data
//  Brief    : Avalon-MM input PIO slave with synchroniser, per-bit edge
//             capture (W1C), interrupt mask and level interrupt output.
//  Revision : 1.0  initial release
// ============================================================================
module soc_system_read_data #(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int c_EDGE_RISE = 0;
    localparam int c_EDGE_FALL = 1;

    localparam logic [1:0] c_ADDR_DATA    = 2'd0;
    localparam logic [1:0] c_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] c_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGECAP = 2'd3;

    localparam logic [1:0] c_WARM_DONE = 2'd3;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [31:0]      r_readdata;
    logic [1:0]       r_warm;

    logic             w_write;
    logic             w_capture_en;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] w_edge_capture_next;
    logic [31:0]      w_read_mux;

    assign w_write      = chipselect & ~write_n;
    assign w_capture_en = (r_warm == c_WARM_DONE);
    assign w_rise       = r_sync2 & ~r_prev;
    assign w_fall       = ~r_sync2 & r_prev;

    generate
        if (EDGE_TYPE == c_EDGE_RISE) begin : g_edge_rise
            assign w_edge = w_rise;
        end else if (EDGE_TYPE == c_EDGE_FALL) begin : g_edge_fall
            assign w_edge = w_fall;
        end else begin : g_edge_any
            assign w_edge = w_rise | w_fall;
        end
    endgenerate

    generate
        if (WIDTH < 32) begin : g_wdata_unused
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // A new edge in the same cycle as a W1C clear keeps the bit set.
    always_comb begin
        w_clear = '0;
        if (w_write && (address == c_ADDR_EDGECAP)) begin
            w_clear = writedata[WIDTH-1:0];
        end
        w_edge_capture_next = r_edge_capture & ~w_clear;
        if (w_capture_en) begin
            w_edge_capture_next = w_edge_capture_next | w_edge;
        end
    end

    always_comb begin
        w_read_mux = '0;
        case (address)
            c_ADDR_DATA:    w_read_mux[WIDTH-1:0] = r_sync2;
            c_ADDR_RSVD:    w_read_mux = '0;
            c_ADDR_IRQMASK: w_read_mux[WIDTH-1:0] = r_irq_mask;
            c_ADDR_EDGECAP: w_read_mux[WIDTH-1:0] = r_edge_capture;
            default:        w_read_mux = '0;
        endcase
    end

    // Warm-up holds off capture until prev has seen real synchronised data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_prev         <= '0;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_readdata     <= '0;
            r_warm         <= '0;
        end else begin
            r_sync1        <= in_port;
            r_sync2        <= r_sync1;
            r_prev         <= r_sync2;
            r_edge_capture <= w_edge_capture_next;
            r_readdata     <= w_read_mux;
            if (r_warm != c_WARM_DONE) begin
                r_warm <= r_warm + 2'd1;
            end
            if (w_write && (address == c_ADDR_IRQMASK)) begin
                r_irq_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_read_data.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_system_read_data
//  Brief    : Directed self-checking bench; one instance per edge mode
//             (rising-only and any-edge) sharing the Avalon bus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_system_read_data;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in0;
    logic [7:0]  in2;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic        irq0;
    logic        irq2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    soc_system_read_data #(.WIDTH(8), .EDGE_TYPE(0)) dut_rise (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in0),
        .readdata   (rd0),
        .irq        (irq0)
    );

    soc_system_read_data #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in2),
        .readdata   (rd2),
        .irq        (irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
        address = a;
        @(negedge clk);
        d0 = rd0;
        d2 = rd2;
    endtask

    logic [31:0] d0, d2;

    initial begin
        reset_n    = 1'b1;
        address    = 2'd3;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in0        = 8'hFF;
        in2        = 8'h00;
        #1 reset_n = 1'b0;
        wait_cyc(3);
        check("rst_rdata", rd0, 32'h0);
        check("rst_irq", {31'b0, irq0}, 32'h0);

        // Static FF through reset must not produce a capture
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("warm_edgecap", rd0, 32'h0);
            check("warm_irq", {31'b0, irq0}, 32'h0);
        end
        bus_read(2'd0, d0, d2);
        check("data_ff", d0, 32'h0000_00FF);

        // Rising bit0 with mask 01: capture at 3rd edge
        bus_write(2'd2, 32'h01);
        in0 = 8'hFE;
        wait_cyc(5);
        in0 = 8'hFF;
        wait_cyc(2);
        check("irq_edge2", {31'b0, irq0}, 32'h0);
        wait_cyc(1);
        check("irq_edge3", {31'b0, irq0}, 32'h1);
        bus_read(2'd3, d0, d2);
        check("cap_bit0", d0, 32'h01);
        bus_write(2'd3, 32'h01);
        check("w1c_irq", {31'b0, irq0}, 32'h0);
        bus_read(2'd3, d0, d2);
        check("w1c_cap", d0, 32'h00);

        // Bit1 with mask 00: falling ignored, rising captured but not interrupting
        bus_write(2'd2, 32'h00);
        in0 = 8'hFD;
        wait_cyc(5);
        bus_read(2'd3, d0, d2);
        check("fall_ignored", d0, 32'h00);
        in0 = 8'hFF;
        wait_cyc(5);
        bus_read(2'd3, d0, d2);
        check("cap_bit1", d0, 32'h02);
        check("masked_irq", {31'b0, irq0}, 32'h0);
        bus_write(2'd2, 32'h02);
        check("mask_irq", {31'b0, irq0}, 32'h1);
        bus_write(2'd3, 32'h02);
        check("clr_bit1_irq", {31'b0, irq0}, 32'h0);

        // W1C coinciding with a new bit0 edge: bit stays set
        bus_write(2'd2, 32'h01);
        in0 = 8'hFE;
        wait_cyc(5);
        in0 = 8'hFF;
        wait_cyc(5);
        in0 = 8'hFE;
        wait_cyc(5);
        in0 = 8'hFF;
        wait_cyc(2);
        bus_write(2'd3, 32'h01);
        check("race_irq", {31'b0, irq0}, 32'h1);
        bus_read(2'd3, d0, d2);
        check("race_cap", d0, 32'h01);
        bus_write(2'd3, 32'h01);
        check("race_clr", {31'b0, irq0}, 32'h0);

        // Any-edge instance: bit7 toggles, DATA follows after 2+1 edges
        bus_write(2'd2, 32'h80);
        in2 = 8'h80;
        wait_cyc(5);
        check("any_rise_irq", {31'b0, irq2}, 32'h1);
        bus_write(2'd3, 32'h80);
        check("any_clr1", {31'b0, irq2}, 32'h0);
        address = 2'd0;
        wait_cyc(2);
        in2 = 8'h00;
        wait_cyc(2);
        check("data2_e2_old", rd2, 32'h80);
        wait_cyc(1);
        check("data2_e3_new", rd2, 32'h00);
        check("any_fall_irq", {31'b0, irq2}, 32'h1);
        bus_write(2'd3, 32'h80);
        check("any_clr2", {31'b0, irq2}, 32'h0);
        address = 2'd0;
        wait_cyc(3);
        in2 = 8'h80;
        wait_cyc(2);
        check("data2_e2_low", rd2, 32'h00);
        wait_cyc(1);
        check("data2_e3_high", rd2, 32'h80);
        check("any_rise2_irq", {31'b0, irq2}, 32'h1);

        // Reserved word, upper bits, read latency, ignored writes
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, d0, d2);
        check("mask_upper0", d0, 32'h0000_00FF);
        bus_read(2'd1, d0, d2);
        check("rsvd_zero", d0, 32'h0);
        address = 2'd2;
        #1 check("lat_old", rd0, 32'h0);
        @(negedge clk);
        check("lat_new", rd0, 32'h0000_00FF);
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'h1234_5678);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd0, d0, d2);
        check("data_ro", d0, 32'h0000_00FF);
        bus_read(2'd1, d0, d2);
        check("rsvd_ro", d0, 32'h0);
        bus_read(2'd2, d0, d2);
        check("mask_kept", d0, 32'h0);

        // Reset mid-operation drops pending capture, warm-up restarts
        bus_write(2'd2, 32'h01);
        in0 = 8'hFE;
        wait_cyc(5);
        in0 = 8'hFF;
        wait_cyc(5);
        check("pre_rst_irq", {31'b0, irq0}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_irq", {31'b0, irq0}, 32'h0);
        check("mid_rst_rdata", rd0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(5);
        check("post_rst_irq", {31'b0, irq0}, 32'h0);
        bus_read(2'd3, d0, d2);
        check("post_rst_cap", d0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
